// File: rtl/txn_wbuf.sv
// Posted-write buffer: writes queue in a FIFO and are acked with zero wait; reads wait behind all queued writes.
// up_rdy drops while the FIFO is full or a read is outstanding; one downstream transaction at a time.
module txn_wbuf #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     up_req,
  input  logic                     up_wr,
  input  logic [AW-1:0]            up_addr,
  input  logic [DW-1:0]            up_wdata,
  output logic [DW-1:0]            up_rdata,
  output logic                     up_rdy,
  output logic                     dn_req,
  output logic                     dn_wr,
  output logic [AW-1:0]            dn_addr,
  output logic [DW-1:0]            dn_wdata,
  input  logic [DW-1:0]            dn_rdata,
  input  logic                     dn_rdy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic {U_IDLE, U_READ} ustate_t;
  typedef enum logic [1:0] {D_IDLE, D_REQ, D_WAIT0, D_WAIT1} dstate_t;

  ustate_t ustate, ustate_next;
  dstate_t dstate;

  logic [AW-1:0] fifo_addr [DEPTH];
  logic [DW-1:0] fifo_data [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [AW-1:0] rd_addr;
  logic          rd_issued;

  logic          push, rd_acc, pop, rd_done;
  logic [LW-1:0] level_next;

  always_comb begin
    push        = up_req && up_rdy && up_wr;
    rd_acc      = up_req && up_rdy && !up_wr;
    pop         = (dstate == D_IDLE) && (level != '0);
    // dn_wr stays loaded for the whole transaction, so it tells a read completion from a write one
    rd_done     = (dstate == D_WAIT1) && dn_rdy && !dn_wr;
    level_next  = level + LW'(push) - LW'(pop);
    ustate_next = ustate;
    if (rd_acc)       ustate_next = U_READ;
    else if (rd_done) ustate_next = U_IDLE;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= up_addr;
      fifo_data[wr_ptr] <= up_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ustate    <= U_IDLE;
      dstate    <= D_IDLE;
      up_rdy    <= 1'b1;
      up_rdata  <= '0;
      dn_req    <= 1'b0;
      dn_wr     <= 1'b0;
      dn_addr   <= '0;
      dn_wdata  <= '0;
      level     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_addr   <= '0;
      rd_issued <= 1'b0;
    end else begin
      ustate <= ustate_next;
      level  <= level_next;
      up_rdy <= (ustate_next == U_IDLE) && (level_next < LW'(DEPTH));
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) begin
        rd_addr   <= up_addr;
        rd_issued <= 1'b0;
      end
      if (rd_done) up_rdata <= dn_rdata;

      case (dstate)
        D_IDLE: begin
          // queued writes always drain before a pending read goes out
          if (pop) begin
            dn_addr  <= fifo_addr[rd_ptr];
            dn_wdata <= fifo_data[rd_ptr];
            dn_wr    <= 1'b1;
            dn_req   <= 1'b1;
            rd_ptr   <= rd_ptr + PW'(1);
            dstate   <= D_REQ;
          end else if (ustate == U_READ && !rd_issued) begin
            dn_addr   <= rd_addr;
            dn_wr     <= 1'b0;
            dn_req    <= 1'b1;
            rd_issued <= 1'b1;
            dstate    <= D_REQ;
          end
        end
        D_REQ: begin
          if (dn_rdy) begin
            dn_req <= 1'b0;
            dstate <= D_WAIT0;
          end
        end
        D_WAIT0: if (!dn_rdy) dstate <= D_WAIT1;
        D_WAIT1: if (dn_rdy)  dstate <= D_IDLE;
        default: dstate <= D_IDLE;
      endcase
    end
  end

  assign idle = (level == '0) && (dstate == D_IDLE) && (ustate == U_IDLE);

endmodule

// File: tb/tb_txn_wbuf.sv
// Bench for txn_wbuf: wait-state memory slave, vector table, corner sequences, random traffic vs. a program-order model.
module tb_txn_wbuf;
  localparam int DEPTH = 4;
  localparam int LIM   = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        up_req, up_wr;
  logic [31:0] up_addr, up_wdata, up_rdata;
  logic        up_rdy;
  logic        dn_req, dn_wr;
  logic [31:0] dn_addr, dn_wdata, dn_rdata;
  logic        dn_rdy;
  logic [2:0]  level;
  logic        idle;

  always #5 clk = ~clk;

  txn_wbuf #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .up_req(up_req), .up_wr(up_wr), .up_addr(up_addr), .up_wdata(up_wdata),
    .up_rdata(up_rdata), .up_rdy(up_rdy),
    .dn_req(dn_req), .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_wdata(dn_wdata),
    .dn_rdata(dn_rdata), .dn_rdy(dn_rdy),
    .level(level), .idle(idle)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory slave: drops rdy on accept, holds it low for m_cnt+1 cycles, then completes.
  logic [31:0] mem [4096];
  bit          wrote [4096];
  logic        m_rdy, m_wr;
  logic [2:0]  m_cnt;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [64:0] mlog [$];
  bit          rand_mode = 1'b0;

  function automatic logic [31:0] init_word(input int idx);
    if (idx == 1) return 32'h12345678;
    return (32'h9E3779B9 * 32'(idx)) ^ 32'hA5A50000;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[13:2]);
  endfunction

  assign dn_rdy   = m_rdy;
  assign dn_rdata = m_rdata;

  always @(posedge clk) begin
    if (rst) begin
      m_rdy <= 1'b1;
      m_cnt <= 3'd0;
    end else if (m_rdy && dn_req) begin
      m_rdy   <= 1'b0;
      m_cnt   <= rand_mode ? 3'($urandom_range(0, 4)) : 3'd4;
      m_wr    <= dn_wr;
      m_addr  <= dn_addr;
      m_wdata <= dn_wdata;
      mlog.push_back({dn_wr, dn_addr, dn_wr ? dn_wdata : 32'h0});
    end else if (!m_rdy) begin
      if (m_cnt == 3'd0) begin
        m_rdy <= 1'b1;
        if (m_wr) begin
          mem[widx(m_addr)]   <= m_wdata;
          wrote[widx(m_addr)] <= 1'b1;
        end else begin
          m_rdata <= wrote[widx(m_addr)] ? mem[widx(m_addr)] : init_word(widx(m_addr));
        end
      end else begin
        m_cnt <= m_cnt - 3'd1;
      end
    end
  end

  // Occupancy watch, sampled before the edge updates the DUT registers.
  int peak = 0;
  int viol = 0;
  bit peak_clr = 1'b1;
  always @(posedge clk) begin
    if (peak_clr) peak <= 0;
    else if (int'(level) > peak) peak <= int'(level);
    if (!rst && int'(level) > DEPTH) viol <= viol + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All stimulus tasks start and end on a falling edge.
  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d, output int waits);
    up_req = 1'b1; up_wr = wr; up_addr = a; up_wdata = d;
    waits = 0;
    while (!up_rdy && waits < LIM) begin
      @(negedge clk);
      waits++;
    end
    if (!up_rdy) begin
      chk("accept_timeout", 65'(up_rdy), 65'(1));
      up_req = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input int exp_lat, input string nm);
    int w, lat;
    issue(1'b0, a, 32'h0, w);
    up_req = 1'b0;
    lat = 0;
    while (!up_rdy && lat < LIM) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_rdata"}, 65'(up_rdata), 65'(exp));
    if (exp_lat >= 0) chk({nm, "_lat"}, 65'(lat), 65'(exp_lat));
  endtask

  task automatic drain();
    int n;
    up_req = 1'b0;
    n = 0;
    while (!idle && n < LIM) begin
      @(negedge clk);
      n++;
    end
    chk("drain_idle", 65'(idle), 65'(1));
  endtask

  typedef struct {
    bit          drain;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t        tbl [7];
  logic [31:0] ref_mem [8];
  logic [64:0] exp_log [$];

  initial begin
    int w, n, base, stall;
    logic [31:0] a, d;
    int k, gap;
    bit wr;

    tbl[0] = '{1'b1, 1'b0, 32'h40000004, 32'h0, 32'h12345678, 8};
    tbl[1] = '{1'b1, 1'b0, 32'h40002000, 32'h0, 32'hDEADBEEF, 8};
    tbl[2] = '{1'b1, 1'b1, 32'h40000100, 32'h1, 32'h0, 0};
    tbl[3] = '{1'b0, 1'b1, 32'h40000100, 32'h2, 32'h0, 0};
    tbl[4] = '{1'b0, 1'b0, 32'h40000100, 32'h0, 32'h2, 22};
    tbl[5] = '{1'b1, 1'b1, 32'h40000200, 32'hCAFEF00D, 32'h0, 0};
    tbl[6] = '{1'b0, 1'b0, 32'h40000200, 32'h0, 32'hCAFEF00D, 15};

    rst = 1'b1; up_req = 1'b0; up_wr = 1'b0; up_addr = '0; up_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_up_rdy", 65'(up_rdy), 65'(1));
    chk("rst_up_rdata", 65'(up_rdata), 65'(0));
    chk("rst_dn_req", 65'(dn_req), 65'(0));
    chk("rst_dn_wr", 65'(dn_wr), 65'(0));
    chk("rst_dn_addr", 65'(dn_addr), 65'(0));
    chk("rst_dn_wdata", 65'(dn_wdata), 65'(0));
    chk("rst_level", 65'(level), 65'(0));
    chk("rst_idle", 65'(idle), 65'(1));

    // Single posted write: zero wait, level 1 for one cycle, idle 8 cycles after accept.
    issue(1'b1, 32'h40002000, 32'hDEADBEEF, w);
    up_req = 1'b0;
    chk("w1_wait", 65'(w), 65'(0));
    chk("w1_level1", 65'(level), 65'(1));
    chk("w1_rdy", 65'(up_rdy), 65'(1));
    n = 0;
    while (!idle && n < LIM) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("w1_level0", 65'(level), 65'(0));
    end
    chk("w1_idle_lat", 65'(n), 65'(8));

    base = mlog.size();
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].drain) drain();
      if (tbl[i].wr) begin
        issue(1'b1, tbl[i].addr, tbl[i].data, w);
        chk($sformatf("vec%0d_wait", i), 65'(w), 65'(tbl[i].exp_lat));
      end else begin
        do_read(tbl[i].addr, tbl[i].exp_rdata, tbl[i].exp_lat, $sformatf("vec%0d", i));
      end
    end
    drain();
    // Read-after-write ordering seen at the memory for the A<-1, A<-2, read A sequence.
    chk("raw_order0", mlog[base + 2], {1'b1, 32'h40000100, 32'h1});
    chk("raw_order1", mlog[base + 3], {1'b1, 32'h40000100, 32'h2});
    chk("raw_order2", mlog[base + 4], {1'b0, 32'h40000100, 32'h0});

    // Six back-to-back writes: FIFO fills, up_rdy stalls the sixth, nothing lost.
    peak_clr = 1'b1;
    @(negedge clk);
    peak_clr = 1'b0;
    base = mlog.size();
    stall = 0;
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, 32'h40000300 + 32'(4 * i), 32'hA0 + 32'(i), w);
      stall += w;
    end
    drain();
    chk("six_stall", 65'(stall), 65'(5));
    chk("six_peak", 65'(peak), 65'(4));
    chk("six_count", 65'(mlog.size() - base), 65'(6));
    for (int i = 0; i < 6; i++)
      chk($sformatf("six_mem%0d", i), mlog[base + i], {1'b1, 32'h40000300 + 32'(4 * i), 32'hA0 + 32'(i)});

    // Reset while the first of four writes waits for completion and three are queued.
    for (int i = 0; i < 4; i++) issue(1'b1, 32'h40000400 + 32'(4 * i), 32'hB0 + 32'(i), w);
    up_req = 1'b0;
    chk("prerst_level", 65'(level), 65'(3));
    chk("prerst_dn_req", 65'(dn_req), 65'(0));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_level", 65'(level), 65'(0));
    chk("mrst_dn_req", 65'(dn_req), 65'(0));
    chk("mrst_up_rdy", 65'(up_rdy), 65'(1));
    chk("mrst_idle", 65'(idle), 65'(1));
    do_read(32'h40000004, 32'h12345678, 8, "post_rst_rd");

    // Random traffic with random memory wait states; model: memory updated in program order.
    drain();
    rand_mode = 1'b1;
    for (int i = 0; i < 8; i++) ref_mem[i] = init_word(12'h400 + i);
    base = mlog.size();
    for (int t = 0; t < 120; t++) begin
      wr  = 1'($urandom_range(0, 1));
      k   = $urandom_range(0, 7);
      a   = 32'h40001000 + 32'(4 * k);
      d   = $urandom;
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        up_req = 1'b0;
        repeat (gap) @(negedge clk);
      end
      if (wr) begin
        issue(1'b1, a, d, w);
        ref_mem[k] = d;
        exp_log.push_back({1'b1, a, d});
      end else begin
        exp_log.push_back({1'b0, a, 32'h0});
        do_read(a, ref_mem[k], -1, $sformatf("rnd%0d", t));
      end
    end
    drain();
    chk("rnd_count", 65'(mlog.size() - base), 65'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && base + i < mlog.size(); i++)
      chk($sformatf("rnd_order%0d", i), mlog[base + i], exp_log[i]);

    chk("level_bound_viol", 65'(viol), 65'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/txn_wbuf.md
Name: txn_wbuf

Overview:
- Posted-write buffer and transaction sequencer between the path fabric's txn master port and the external memory slave.
- Fabric path writes are queued in a FIFO and acknowledged with zero wait, so neighbour updates are not stalled by memory latency.
- Reads from the cost map are ordered behind all earlier writes and forwarded one at a time.
- An idle flag tells the host when all posted writes have reached memory, so the path table is safe to read back.

Parameters:
- DEPTH, 4, write FIFO entries (power of two, >=2).
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- up_req  in  1  upstream transaction request (from fabric txn_req).
- up_wr  in  1  1 = write, 0 = read.
- up_addr  in  AW  upstream address, passed to memory unmodified.
- up_wdata  in  DW  upstream write data.
- up_rdata  out  DW  read return data, valid while up_rdy=1 after a read.
- up_rdy  out  1  ready/done to fabric, registered.
- dn_req  out  1  downstream request to memory, registered.
- dn_wr  out  1  downstream write strobe, registered.
- dn_addr  out  AW  downstream address, registered.
- dn_wdata  out  DW  downstream write data, registered.
- dn_rdata  in  DW  memory read data.
- dn_rdy  in  1  memory ready/done.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- idle  out  1  FIFO empty, no downstream transaction, no read pending.

Behaviour:
- Reset values: up_rdy=1, up_rdata=0, dn_req=0, dn_wr=0, dn_addr=0, dn_wdata=0, level=0, idle=1. Both FSMs go to IDLE.
- Reset mid-operation drops queued writes and abandons any in-flight downstream transaction. dn_req is 0 on the cycle after the reset edge.
- Upstream acceptance: a transaction is accepted on a rising edge where up_req=1 and up_rdy=1. An edge with up_req=1 and up_rdy=0 is ignored; the master holds its request.
- Upstream FSM has two states, U_IDLE and U_READ.
- up_rdy is registered as (next ustate==U_IDLE && level_next<DEPTH).
- Write accept:
  - {addr,wdata} is pushed to the FIFO.
  - up_rdy stays 1 unless level_next==DEPTH. Back-to-back writes are taken one per cycle.
- Read accept:
  - addr is latched and ustate goes to U_READ; up_rdy=0 from the next cycle.
  - Return to U_IDLE happens on the downstream read completion edge. On that edge up_rdata<=dn_rdata and up_rdy<=1.
  - up_rdata holds its value until the next read completes.
- Downstream FSM has four states: D_IDLE, D_REQ, D_WAIT0, D_WAIT1.
- D_IDLE priority:
  - FIFO non-empty: pop the head, load dn_addr/dn_wdata, dn_wr=1, go to D_REQ.
  - Otherwise, if U_READ is pending and not yet issued: load the read address, dn_wr=0, go to D_REQ.
  - Writes always precede a pending read (read-after-write ordering). Writes pushed while a read is waiting cannot occur, because up_rdy=0.
- D_REQ: dn_req=1. On an edge with dn_rdy=1, dn_req<=0 and go to D_WAIT0.
- D_WAIT0: on dn_rdy sampled 0, go to D_WAIT1.
- D_WAIT1: on dn_rdy sampled 1, the transaction is complete; go to D_IDLE.
- Simultaneous push and pop on one edge leaves level unchanged. Overflow and underflow are impossible by construction; the bench asserts both.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- idle is combinational from registers: level==0 && D_IDLE && U_IDLE.
- Latency with a slave that drops rdy on the accept edge and returns it after 4 wait cycles (standard memory model, CNT=4), FIFO empty:
  - read accept edge E0; dn_req high after E1; memory accepts at E2; up_rdy returns high after E8.
  - A single write costs upstream zero wait cycles; idle returns 1 after the same 8 edges.

Test Plan:
- Single write 0x40002000<-0xDEADBEEF, idle bench:
  - up_rdy stays 1; level=1 for one cycle.
  - The memory slot receives the value; idle=1 again 8 cycles after accept.
- Single read 0x40000004 with the memory word = 0x12345678:
  - up_rdy=0 for E1..E8, then 1 with up_rdata=0x12345678.
- Six back-to-back writes to consecutive addresses:
  - up_rdy drops when level reaches 4; no write is lost.
  - Memory receives all six in order; level never exceeds 4.
- Write A<-1, write A<-2, then read A:
  - The read returns 2.
  - The read is issued downstream only after both writes complete.
- Assert rst while D_WAIT1 holds 3 queued writes:
  - Next cycle: level=0, dn_req=0, up_rdy=1, idle=1.
  - A following read completes normally.
- Full-fabric run (DIM=28) through txn_wbuf: the path dump after idle && int_done matches the dump from the unbuffered run word for word.
